// File: rtl/ro_reader_pkg.sv
// Shared types and defaults for the ring-oscillator count reader.
// Holds the reader state enum, the parameter defaults and the result-width helper.
package ro_reader_pkg;

    localparam int DEF_CNT_WIDTH     = 32;
    localparam int DEF_WIN_WIDTH     = 16;
    localparam int DEF_CLR_CYCLES    = 2;
    localparam int DEF_SETTLE_CYCLES = 4;
    localparam int DEF_ACC_LOG2      = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_WINDOW  = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_HOLD    = 3'd5
    } ro_rd_state_e;

    // Result width is sized so that 2**acc_log2 full-scale counts cannot overflow.
    function automatic int res_width(input int cnt_w, input int acc_log2);
        return cnt_w + acc_log2;
    endfunction

endpackage

// File: rtl/ro_window_timer.sv
// Loadable down-counter shared by the CLEAR, WINDOW and SETTLE phases.
// A phase loaded with N lasts N cycles; done_o marks its last cycle.
module ro_window_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         async_reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins, otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != {W{1'b0}}) begin
            cnt_d = cnt_q - W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/ro_count_reader.sv
// Controller/reader for a ring-oscillator counter: clear, timed window, settle, capture, hand off.
// Define RO_READER_ACCUM_EN to sum 2**ACC_LOG2 back-to-back windows per start.
module ro_count_reader
    import ro_reader_pkg::*;
#(
    parameter int CNT_WIDTH     = DEF_CNT_WIDTH,
    parameter int WIN_WIDTH     = DEF_WIN_WIDTH,
    parameter int CLR_CYCLES    = DEF_CLR_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int ACC_LOG2      = DEF_ACC_LOG2
) (
    input  logic                          clk,
    input  logic                          async_reset,
    input  logic                          start,
    input  logic [WIN_WIDTH-1:0]          window_cycles,
    output logic                          ro_enable,
    output logic                          ro_reset,
    input  logic [CNT_WIDTH-1:0]          ro_count,
    output logic                          busy,
    output logic [CNT_WIDTH+ACC_LOG2-1:0] result_data,
    output logic                          result_valid,
    input  logic                          result_ready
);

    localparam int RES_W = res_width(CNT_WIDTH, ACC_LOG2);

    ro_rd_state_e         state_q, state_d;
    logic [WIN_WIDTH-1:0] win_q, win_d;
    logic [RES_W-1:0]     res_q, res_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 ro_enable_q, ro_enable_d;
    logic                 ro_reset_q, ro_reset_d;
    logic                 tmr_load_s;
    logic [WIN_WIDTH-1:0] tmr_val_s;
    logic                 tmr_done_s;
`ifdef RO_READER_ACCUM_EN
    logic [ACC_LOG2-1:0]  pass_q, pass_d;
`endif

    ro_window_timer #(
        .W (WIN_WIDTH)
    ) u_timer (
        .clk         (clk),
        .async_reset (async_reset),
        .load_i      (tmr_load_s),
        .load_val_i  (tmr_val_s),
        .done_o      (tmr_done_s)
    );

    // Next-state, timer loads, capture/accumulate and handshake.
    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        res_d      = res_q;
        valid_d    = valid_q;
        tmr_load_s = 1'b0;
        tmr_val_s  = win_q;
`ifdef RO_READER_ACCUM_EN
        pass_d     = pass_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_CLEAR;
                    win_d      = (window_cycles == {WIN_WIDTH{1'b0}}) ? WIN_WIDTH'(1) : window_cycles;
                    res_d      = {RES_W{1'b0}};
                    tmr_load_s = 1'b1;
                    tmr_val_s  = WIN_WIDTH'(CLR_CYCLES);
`ifdef RO_READER_ACCUM_EN
                    pass_d     = {ACC_LOG2{1'b0}};
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (tmr_done_s) begin
                    state_d    = ST_WINDOW;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = win_q;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_WINDOW: begin
                if (tmr_done_s) begin
                    state_d    = ST_SETTLE;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = WIN_WIDTH'(SETTLE_CYCLES);
                end else begin
                    state_d = ST_WINDOW;
                end
            end
            ST_SETTLE: begin
                if (tmr_done_s) begin
                    state_d = ST_CAPTURE;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_CAPTURE: begin
                // The counter has been frozen for SETTLE_CYCLES, so a multi-bit sample is coherent.
`ifdef RO_READER_ACCUM_EN
                res_d = res_q + RES_W'(ro_count);
                if (pass_q == {ACC_LOG2{1'b1}}) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d    = ST_CLEAR;
                    pass_d     = pass_q + ACC_LOG2'(1);
                    tmr_load_s = 1'b1;
                    tmr_val_s  = WIN_WIDTH'(CLR_CYCLES);
                end
`else
                res_d   = RES_W'(ro_count);
                state_d = ST_HOLD;
`endif
            end
            ST_HOLD: begin
                // valid rises one cycle into HOLD so the accept edge can drop it cleanly.
                if (valid_q && result_ready) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end else begin
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
        ro_enable_d = (state_q == ST_WINDOW);
        ro_reset_d  = (state_q == ST_IDLE) || (state_q == ST_CLEAR);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and output registers; RO controls lag the FSM by one cycle and stay glitch-free.
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            state_q     <= ST_IDLE;
            win_q       <= {WIN_WIDTH{1'b0}};
            res_q       <= {RES_W{1'b0}};
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            ro_enable_q <= 1'b0;
            ro_reset_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            res_q       <= res_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            ro_enable_q <= ro_enable_d;
            ro_reset_q  <= ro_reset_d;
        end
    end

`ifdef RO_READER_ACCUM_EN
    // Pass counter for the accumulating build.
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            pass_q <= {ACC_LOG2{1'b0}};
        end else begin
            pass_q <= pass_d;
        end
    end
`endif

    assign ro_enable    = ro_enable_q;
    assign ro_reset     = ro_reset_q;
    assign busy         = busy_q;
    assign result_valid = valid_q;
    assign result_data  = res_q;

endmodule
